// File: rtl/sync_ram_master.sv
// Request/response initiator for a 1-cycle-latency synchronous RAM.
// Reads return in order through a show-ahead response FIFO, and credits prevent FIFO overflow.
module sync_ram_master #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    // Wide enough for a full FIFO plus both pipeline stages.
    localparam int CNT_W = PTR_W + 2;

    logic              s1_rd_reg;
    logic              s2_rd_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] mem_reg [RSP_DEPTH];

    logic              accept;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  credit_used;

    // Every read in flight has a reserved slot, so a capture never finds the FIFO full.
    assign credit_used = count_reg + CNT_W'(s1_rd_reg) + CNT_W'(s2_rd_reg);
    assign req_ready   = credit_used < CNT_W'(RSP_DEPTH);
    assign accept      = req_valid & req_ready;
    assign push        = s2_rd_reg;
    assign pop         = rsp_valid & rsp_ready;
    assign rsp_valid   = (count_reg != '0);
    assign rsp_rdata   = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            s1_rd_reg <= 1'b0;
            s2_rd_reg <= 1'b0;
        end else begin
            if (accept) begin
                ram_we    <= req_we;
                ram_addr  <= req_addr;
                ram_din   <= req_wdata;
                s1_rd_reg <= ~req_we;
            end else begin
                ram_we    <= 1'b0;
                s1_rd_reg <= 1'b0;
            end
            s2_rd_reg <= s1_rd_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= ram_dout;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
